// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory arbiter: access codes, controller states,
// default memory size and the request legality checks.
package mem_ctrl_pkg;

    localparam int unsigned DEPTH_DEFAULT = 64;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_BYTE = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        CAPTURE = 2'b10,
        RESP    = 2'b11
    } state_t;

    // A data request must carry exactly one non-reserved code and stay inside memory.
    function automatic logic data_illegal(input logic [1:0]  rd,
                                          input logic [1:0]  wr,
                                          input logic [31:0] addr,
                                          input int unsigned depth);
        logic [1:0] code;
        logic       bad;
        code = (rd != MEM_NONE) ? rd : wr;
        bad  = 1'b0;
        if ((rd != MEM_NONE) == (wr != MEM_NONE)) bad = 1'b1;
        if ((rd == 2'b10) || (wr == 2'b10))       bad = 1'b1;
        if ((code == MEM_BYTE) && (addr > 32'(depth - 1))) bad = 1'b1;
        if ((code == MEM_WORD) && (addr > 32'(depth - 4))) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic fetch_illegal(input logic [31:0] addr,
                                           input int unsigned depth);
        return (addr > 32'(depth - 4)) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Index 0 is the fetch port, index 1 the data port;
// the last-grant register resets to fetch so data wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic last_data_q;
    logic last_data_d;
    logic [1:0] gnt;

    always_comb begin
        gnt = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt = last_data_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req_i;
            end
        end
        last_data_d = last_data_q;
        if (gnt != 2'b00) begin
            last_data_d = gnt[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_data_q <= 1'b0;
        end else begin
            last_data_q <= last_data_d;
        end
    end

    assign gnt_o = gnt;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported byte memory between a fetch port and a data port.
// Handshake: a port raises req with its fields held until a one-cycle ready pulse; err qualifies ready.
module mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic [1:0]  d_mem_read,
    input  logic [1:0]  d_mem_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic [1:0]  mem_read,
    output logic [1:0]  mem_write,
    output logic [31:0] address,
    output logic [31:0] word_in,
    input  logic [31:0] word_out,
    output state_t      dbg_state
);

    state_t      state_q, state_d;
    logic        gnt_data_q, gnt_data_d;
    logic [1:0]  rd_q, rd_d;
    logic [1:0]  wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [1:0]  gnt;
    logic        d_bad;
    logic        if_bad;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req_i ({d_req, if_req}),
        .en_i  (state_q == IDLE),
        .gnt_o (gnt)
    );

    assign d_bad  = data_illegal(d_mem_read, d_mem_write, d_addr, DEPTH);
    assign if_bad = fetch_illegal(if_addr, DEPTH);

    always_comb begin
        state_d    = state_q;
        gnt_data_d = gnt_data_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (gnt[1]) begin
                    gnt_data_d = 1'b1;
                    rd_d       = d_mem_read;
                    wr_d       = d_mem_write;
                    addr_d     = d_addr;
                    wdata_d    = d_wdata;
                    err_d      = d_bad;
                    state_d    = d_bad ? RESP : ISSUE;
                end else if (gnt[0]) begin
                    gnt_data_d = 1'b0;
                    rd_d       = MEM_WORD;
                    wr_d       = MEM_NONE;
                    addr_d     = if_addr;
                    wdata_d    = 32'h0;
                    err_d      = if_bad;
                    state_d    = if_bad ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                state_d = (rd_q != MEM_NONE) ? CAPTURE : RESP;
            end
            CAPTURE: begin
                // Byte loads keep only the low lane, zero-extended.
                if (gnt_data_q) begin
                    d_rdata_d = (rd_q == MEM_BYTE) ? {24'h0, word_out[7:0]} : word_out;
                end else begin
                    if_rdata_d = word_out;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_data_q <= 1'b0;
            rd_q       <= MEM_NONE;
            wr_q       <= MEM_NONE;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            err_q      <= 1'b0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            gnt_data_q <= gnt_data_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // The memory bus is quiet outside ISSUE, so it only ever sees legal, granted accesses.
    always_comb begin
        mem_read  = MEM_NONE;
        mem_write = MEM_NONE;
        address   = 32'h0;
        word_in   = 32'h0;
        if (state_q == ISSUE) begin
            mem_read  = rd_q;
            mem_write = wr_q;
            address   = addr_q;
            word_in   = wdata_q;
        end
    end

    assign if_ready  = (state_q == RESP) && !gnt_data_q;
    assign d_ready   = (state_q == RESP) && gnt_data_q;
    assign if_err    = if_ready && err_q;
    assign d_err     = d_ready && err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: big-endian byte memory model, directed port drivers,
// and a scoreboard checking every ready pulse against an expected queue.
module tb_mem_arbiter;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic [1:0]  d_mem_read;
  logic [1:0]  d_mem_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_err;
  logic [31:0] d_rdata;
  logic [1:0]  mem_read;
  logic [1:0]  mem_write;
  logic [31:0] address;
  logic [31:0] word_in;
  logic [31:0] word_out;
  state_t      dbg_state;

  logic [7:0]  mem [0:63];
  logic        mem_init;
  int          acc_cnt;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [33:0] exp_q[$];
  logic [33:0] got;
  logic [33:0] want;

  mem_arbiter #(.DEPTH(64)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
    .d_err(d_err), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .address(address),
    .word_in(word_in), .word_out(word_out), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- memory model (big-endian, byte at addr is MSB) ----------------
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      mem[8] <= 8'h11; mem[9] <= 8'h22; mem[10] <= 8'h33; mem[11] <= 8'h44;
      acc_cnt <= 0;
      word_out <= 32'h0;
    end else begin
      if (mem_read != MEM_NONE || mem_write != MEM_NONE) acc_cnt <= acc_cnt + 1;
      if (mem_write == MEM_WORD) begin
        mem[address[5:0]]          <= word_in[31:24];
        mem[address[5:0] + 6'd1]   <= word_in[23:16];
        mem[address[5:0] + 6'd2]   <= word_in[15:8];
        mem[address[5:0] + 6'd3]   <= word_in[7:0];
      end else if (mem_write == MEM_BYTE) begin
        mem[address[5:0]] <= word_in[7:0];
      end
      if (mem_read == MEM_WORD) begin
        word_out <= {mem[address[5:0]], mem[address[5:0] + 6'd1],
                     mem[address[5:0] + 6'd2], mem[address[5:0] + 6'd3]};
      end else if (mem_read == MEM_BYTE) begin
        word_out <= {24'h0, mem[address[5:0]]};
      end
    end
  end

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected response: {port (1 = data), err, rdata of that port}
  task automatic push_exp(input logic port, input logic err, input logic [31:0] rdata);
    exp_q.push_back({port, err, rdata});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (if_ready || d_ready) begin
      got = {d_ready, (d_ready ? d_err : if_err), (d_ready ? d_rdata : if_rdata)};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got port=%0b err=%0b rdata=0x%08h with nothing expected",
                 got[33], got[32], got[31:0]);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL resp: got port=%0b err=%0b rdata=0x%08h expected port=%0b err=%0b rdata=0x%08h",
                   got[33], got[32], got[31:0], want[33], want[32], want[31:0]);
        end
      end
    end
    if (dbg_state != ISSUE && (mem_read != MEM_NONE || mem_write != MEM_NONE)) begin
      n_tests++;
      n_fail++;
      $display("FAIL bus_quiet: mem_read=%b mem_write=%b in state %0d expected 00/00",
               mem_read, mem_write, dbg_state);
    end
  end

  // ---------------- drivers (called in an IDLE cycle, right after a negedge) ----------------
  task automatic do_fetch(input logic [31:0] addr, input int exp_lat);
    int lat;
    bit done;
    if_addr = addr;
    if_req  = 1'b1;
    lat = 0;
    done = 0;
    while (!done && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (if_ready) done = 1;
    end
    if_req = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL if_timeout: no if_ready after %0d cycles, expected at %0d", lat, exp_lat);
    end else begin
      check("if_latency", 32'(lat), 32'(exp_lat));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_data(input logic [1:0] rd, input logic [1:0] wr,
                         input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat);
    int lat;
    bit done;
    d_mem_read  = rd;
    d_mem_write = wr;
    d_addr      = addr;
    d_wdata     = wdata;
    d_req       = 1'b1;
    lat = 0;
    done = 0;
    while (!done && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (d_ready) done = 1;
    end
    d_req = 1'b0;
    d_mem_read = MEM_NONE;
    d_mem_write = MEM_NONE;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL d_timeout: no d_ready after %0d cycles, expected at %0d", lat, exp_lat);
    end else begin
      check("d_latency", 32'(lat), 32'(exp_lat));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int acc0;

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_mem_read = MEM_NONE; d_mem_write = MEM_NONE;
    d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; mem_init = 1'b0;

    // Reset state
    check("rst_if_ready", {31'h0, if_ready}, 32'h0);
    check("rst_d_ready", {31'h0, d_ready}, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_mem_codes", {28'h0, mem_read, mem_write}, 32'h0);
    check("rst_address", address, 32'h0);
    check("rst_word_in", word_in, 32'h0);

    // Fetch alone from addr 8
    push_exp(1'b0, 1'b0, 32'h11223344);
    do_fetch(32'd8, 3);

    // Store word then load byte
    acc0 = acc_cnt;
    push_exp(1'b1, 1'b0, 32'h0);
    do_data(MEM_NONE, MEM_WORD, 32'd4, 32'hDEADBEEF, 2);
    check("sw_mem", {mem[4], mem[5], mem[6], mem[7]}, 32'hDEADBEEF);
    push_exp(1'b1, 1'b0, 32'h000000AD);
    do_data(MEM_BYTE, MEM_NONE, 32'd5, 32'h0, 3);
    check("access_count", 32'(acc_cnt - acc0), 32'd2);

    // Illegal requests: no memory access, rdata untouched
    acc0 = acc_cnt;
    push_exp(1'b1, 1'b1, 32'h000000AD);
    do_data(MEM_WORD, MEM_NONE, 32'd61, 32'h0, 1);
    push_exp(1'b1, 1'b1, 32'h000000AD);
    do_data(MEM_BYTE, MEM_BYTE, 32'd0, 32'h0, 1);
    push_exp(1'b1, 1'b1, 32'h000000AD);
    do_data(2'b10, MEM_NONE, 32'd0, 32'h0, 1);
    push_exp(1'b1, 1'b0, 32'h000000AD);
    do_data(MEM_NONE, MEM_BYTE, 32'd63, 32'h000000AD, 2);
    push_exp(1'b1, 1'b1, 32'h000000AD);
    do_data(MEM_BYTE, MEM_NONE, 32'd64, 32'h0, 1);
    push_exp(1'b0, 1'b1, 32'h11223344);
    do_fetch(32'd6, 1);
    push_exp(1'b0, 1'b1, 32'h11223344);
    do_fetch(32'd64, 1);
    check("illegal_no_access", 32'(acc_cnt - acc0), 32'd1);
    check("byte_store_63", {24'h0, mem[63]}, 32'h000000AD);

    // Simultaneous requests after reset: data wins first, then fetch
    apply_reset();
    check("rst2_d_rdata", d_rdata, 32'h0);
    push_exp(1'b1, 1'b0, 32'hDEADBEEF);
    push_exp(1'b0, 1'b0, 32'h11223344);
    fork
      do_data(MEM_WORD, MEM_NONE, 32'd4, 32'h0, 3);
      do_fetch(32'd8, 7);
    join

    // Data alone, then a tie: fetch must win this time
    push_exp(1'b1, 1'b0, 32'h00000022);
    do_data(MEM_BYTE, MEM_NONE, 32'd9, 32'h0, 3);
    push_exp(1'b0, 1'b0, 32'h11223344);
    push_exp(1'b1, 1'b0, 32'h00000033);
    fork
      do_fetch(32'd8, 3);
      do_data(MEM_BYTE, MEM_NONE, 32'd10, 32'h0, 7);
    join

    // Reset during CAPTURE aborts without a ready pulse
    if_addr = 32'd8;
    if_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("abort_state", 32'(dbg_state), 32'(CAPTURE));
    reset = 1'b1;
    if_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_if_ready", {31'h0, if_ready}, 32'h0);
    check("abort_if_rdata", if_rdata, 32'h0);
    check("abort_d_rdata", d_rdata, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    push_exp(1'b0, 1'b0, 32'h11223344);
    do_fetch(32'd8, 3);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DEPTH, 64, byte count of the attached memory; legal byte address 0..DEPTH-1.
REQ-002 Port: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: if_req  in  1  fetch port request (word read only); held with if_addr until if_ready.
REQ-005 Port: if_addr  in  32  fetch byte address.
REQ-006 Port: if_ready  out  1  one-cycle completion pulse, fetch port.
REQ-007 Port: if_rdata  out  32  fetched word, registered, stable until next fetch completion.
REQ-008 Port: if_err  out  1  valid with if_ready; fetch rejected.
REQ-009 Port: d_req  in  1  data port request; held with d_* fields until d_ready.
REQ-010 Port: d_mem_read, d_mem_write  in  2 each  access code: 00 none, 01 byte, 11 word.
REQ-011 Port: d_addr, d_wdata  in  32 each  data byte address, store data (byte store uses [7:0]).
REQ-012 Port: d_ready, d_err  out  1 each  completion pulse, rejection flag valid with d_ready.
REQ-013 Port: d_rdata  out  32  loaded data, byte load zero-extended, registered, stable until next data-load completion.
REQ-014 Port: mem_read, mem_write  out  2 each  memory access codes, same encoding.
REQ-015 Port: address, word_in  out  32 each  memory byte address and store data.
REQ-016 Port: word_out  in  32  memory read data, valid from the edge after a read is presented.

Function
REQ-017 States: IDLE, ISSUE, CAPTURE, RESP; mem_read/mem_write SHALL be 00 in every state except ISSUE.
REQ-018 IDLE: no request -> stay; else grant one port, latch its fields, -> ISSUE (legal) or -> RESP with err (illegal).
REQ-019 Arbitration: single request wins; simultaneous requests -> port not granted last (round-robin); last-grant resets to fetch, so data wins the first tie.
REQ-020 ISSUE (1 cycle): drive latched code/address/word_in; read -> CAPTURE, write -> RESP.
REQ-021 CAPTURE (1 cycle): word_out loaded into the granted port's rdata register at cycle end; -> RESP.
REQ-022 RESP (1 cycle): granted port's ready = 1, err per REQ-023/024; -> IDLE; other port's outputs unchanged.
REQ-023 Data request illegal if: both codes nonzero, both zero, any code 10, byte access with addr > DEPTH-1, or word access with addr > DEPTH-4.
REQ-024 Fetch illegal if if_addr > DEPTH-4 or if_addr[1:0] != 00.
REQ-025 Illegal request: no memory access, rdata unchanged, err = 1 with ready.
REQ-026 Latency from request sampled in IDLE (cycle 0): read ready at cycle 3, write ready at cycle 2, illegal ready at cycle 1.
REQ-027 A request still high in the IDLE cycle after its ready SHALL be treated as a new request.
REQ-028 Request inputs changing while not granted SHALL have no effect until sampled in IDLE.

Reset
REQ-029 Reset SHALL force IDLE, last-grant = fetch, all outputs 0 (including rdata registers) on the next edge.
REQ-030 Reset mid-operation SHALL abort without a ready pulse; an aborted ISSUE cycle's access is not retried.

Structure
REQ-031 Package mem_ctrl_pkg SHALL hold access codes (MEM_NONE 00, MEM_BYTE 01, MEM_WORD 11), the state enum, and default DEPTH.
REQ-032 Sub-module rr_arb2 SHALL implement the two-way round-robin grant with last-grant register.

Verification
REQ-033 Fetch alone, addr 8, memory bytes 8..11 = 11 22 33 44 -> if_ready at cycle 3, if_rdata 0x11223344, if_err 0.
REQ-034 Data SW addr 4 data 0xDEADBEEF, then LB addr 5 -> d_ready at cycle 2, then d_rdata 0x000000AD.
REQ-035 if_req and d_req same cycle after reset -> data served first; both held again -> fetch served next.
REQ-036 Data LW addr 61 -> d_ready at cycle 1, d_err 1, mem_read/mem_write stay 00, d_rdata unchanged.
REQ-037 Data mem_read 01 and mem_write 01 together -> d_err 1, no memory access; fetch addr 6 -> if_err 1.
REQ-038 reset asserted during CAPTURE -> no ready pulse, outputs 0 next cycle, following request completes normally.
